pong_renderer: RTL

Pixel-generation stage downstream of the Pong game-logic block. Consumes the square and paddle top-left coordinates plus the VGA timing generator's pixel position, and produces a 12-bit RGB colour per pixel with matching delayed sync signals. Sprite positions are latched once per frame so a frame never shows a sprite half-moved. Output goes straight to the VGA DAC pins.

---
 rtl/pong_renderer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pong_renderer.sv
// Pong pixel renderer: frame-latched sprite positions, hit tests and a
// two-stage colour pipeline with matching sync delay.
module pong_renderer #(
    parameter int          H_VIDEO       = 640,
    parameter int          V_VIDEO       = 480,
    parameter int          SQUARE_WIDTH  = 16,
    parameter int          PADDLE_WIDTH  = 12,
    parameter int          PADDLE_HEIGHT = 96,
    parameter int          NET_SIZE      = 12,
    parameter int          NET_X         = 314,
    parameter logic [11:0] SQUARE_COLOR  = 12'hFFF,
    parameter logic [11:0] PADDLE_COLOR  = 12'hFFF,
    parameter logic [11:0] NET_COLOR     = 12'h888,
    parameter logic [11:0] BG_COLOR      = 12'h000
) (
    input  logic        clk_0,
    input  logic        rst,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        frame_start,
    input  logic [9:0]  square_xpos,
    input  logic [9:0]  square_ypos,
    input  logic [9:0]  paddle1_xpos,
    input  logic [9:0]  paddle1_ypos,
    input  logic [9:0]  paddle2_xpos,
    input  logic [9:0]  paddle2_ypos,
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out
);

    localparam int RW = $clog2(NET_SIZE);
    localparam logic [RW-1:0] ROW_LAST = RW'(NET_SIZE - 1);
    localparam logic [10:0] SQ_EXT = 11'(SQUARE_WIDTH - 1);
    localparam logic [10:0] PW_EXT = 11'(PADDLE_WIDTH - 1);
    localparam logic [10:0] PH_EXT = 11'(PADDLE_HEIGHT - 1);
    localparam logic [10:0] NET_L  = 11'(NET_X);
    localparam logic [10:0] NET_R  = 11'(NET_X + NET_SIZE - 1);

    logic [9:0] sq_x, sq_y, p1_x, p1_y, p2_x, p2_y;

    always_ff @(posedge clk_0 or posedge rst) begin
        if (rst) begin
            sq_x <= 10'd320;
            sq_y <= 10'd240;
            p1_x <= 10'd24;
            p1_y <= 10'd191;
            p2_x <= 10'd603;
            p2_y <= 10'd191;
        end else if (frame_start) begin
            sq_x <= square_xpos;
            sq_y <= square_ypos;
            p1_x <= paddle1_xpos;
            p1_y <= paddle1_ypos;
            p2_x <= paddle2_xpos;
            p2_y <= paddle2_ypos;
        end
    end

    // 11-bit compares so right/bottom edge sums never wrap
    logic [10:0] x11, y11;
    logic        sq_hit, p1_hit, p2_hit, net_hit;

    assign x11 = {1'b0, pixel_x};
    assign y11 = {1'b0, pixel_y};

    assign sq_hit = (x11 >= {1'b0, sq_x}) && (x11 <= {1'b0, sq_x} + SQ_EXT)
                 && (y11 >= {1'b0, sq_y}) && (y11 <= {1'b0, sq_y} + SQ_EXT);
    assign p1_hit = (x11 >= {1'b0, p1_x}) && (x11 <= {1'b0, p1_x} + PW_EXT)
                 && (y11 >= {1'b0, p1_y}) && (y11 <= {1'b0, p1_y} + PH_EXT);
    assign p2_hit = (x11 >= {1'b0, p2_x}) && (x11 <= {1'b0, p2_x} + PW_EXT)
                 && (y11 >= {1'b0, p2_y}) && (y11 <= {1'b0, p2_y} + PH_EXT);

    logic [9:0]    y_prev;
    logic [RW-1:0] row_cnt, row_nxt;
    logic          phase, phase_nxt;

    always_comb begin
        row_nxt   = row_cnt;
        phase_nxt = phase;
        if (pixel_y != y_prev) begin
            if (pixel_y == 10'd0) begin
                row_nxt   = '0;
                phase_nxt = 1'b1;
            end else if (row_cnt == ROW_LAST) begin
                row_nxt   = '0;
                phase_nxt = ~phase;
            end else begin
                row_nxt = row_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_0 or posedge rst) begin
        if (rst) begin
            y_prev  <= '0;
            row_cnt <= '0;
            phase   <= 1'b1;
        end else begin
            y_prev  <= pixel_y;
            row_cnt <= row_nxt;
            phase   <= phase_nxt;
        end
    end

    // next-state phase so a new line's first pixel already sees its segment
    assign net_hit = (x11 >= NET_L) && (x11 <= NET_R) && phase_nxt;

    logic s1_sq, s1_p1, s1_p2, s1_net, s1_von, s1_hs, s1_vs;

    always_ff @(posedge clk_0 or posedge rst) begin
        if (rst) begin
            s1_sq  <= 1'b0;
            s1_p1  <= 1'b0;
            s1_p2  <= 1'b0;
            s1_net <= 1'b0;
            s1_von <= 1'b0;
            s1_hs  <= 1'b1;
            s1_vs  <= 1'b1;
        end else begin
            s1_sq  <= sq_hit;
            s1_p1  <= p1_hit;
            s1_p2  <= p2_hit;
            s1_net <= net_hit;
            s1_von <= video_on;
            s1_hs  <= hsync_in;
            s1_vs  <= vsync_in;
        end
    end

    logic [11:0] color;

    always_comb begin
        color = BG_COLOR;
        if (!s1_von)
            color = 12'h000;
        else if (s1_sq)
            color = SQUARE_COLOR;
        else if (s1_p1 || s1_p2)
            color = PADDLE_COLOR;
        else if (s1_net)
            color = NET_COLOR;
    end

    always_ff @(posedge clk_0 or posedge rst) begin
        if (rst) begin
            rgb       <= 12'h000;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            rgb       <= color;
            hsync_out <= s1_hs;
            vsync_out <= s1_vs;
        end
    end

endmodule
